// File: rtl/serial_add_if.sv
// rtl/serial_add_if.sv - request/result bundle for the bit-serial adder
//
// Purpose: groups the operand request and result signals of serial_add.
// Ports (modport view):
//   master : drives start, a, b, cin; observes busy, done, sum, cout
//   slave  : the adder side; observes start, a, b, cin; drives busy, done, sum, cout
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add.sv
// rtl/serial_add.sv - bit-serial adder built from two half-adder cells and a carry flop
//
// Purpose: captures a, b and cin on an accepted start, then adds one bit per
//          clock LSB-first; sum/cout update only when the last bit is done.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_add_if slave modport
//          start (req, sampled in IDLE), a/b/cin (operands),
//          busy (RUN or DONE), done (one-cycle result pulse),
//          sum/cout (result registers, held between operations)

// h_add - combinational half-adder cell: s = a ^ b, c = a & b
module h_add (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_add_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // One full-adder slice: two half adders, carries merged by OR.
    logic ha0_s, ha0_c, ha1_s, ha1_c;
    logic bit_sum, bit_carry;

    h_add u_ha0 (.a(a_sh_q[0]), .b(b_sh_q[0]), .s(ha0_s), .c(ha0_c));
    h_add u_ha1 (.a(ha0_s),     .b(carry_q),   .s(ha1_s), .c(ha1_c));

    assign bit_sum   = ha1_s;
    assign bit_carry = ha0_c | ha1_c;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                res_sh_d = {bit_sum, res_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = bit_carry;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {bit_sum, res_sh_q[WIDTH-1:1]};
                    cout_d  = bit_carry;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
